lecture_clock: RTL and testbench
================================

// Module: lecture_clock
// PURPOSE
//  In-game lecture clock. Divides Clk into game seconds and game minutes and
//  drives the minutes[7:0] bus read by the game-state FSM (professor trigger,
//  MAX_TIME loss, move enable). Run/pause/expire control lives here; the
//  FSM only consumes the count.
// PARAMETERS
//  TICKS_PER_SEC  100_000_000  Clk cycles per game second (>=2)
//  SEC_PER_MIN    60           game seconds per game minute (2..64)
//  MAX_MIN        8'd255       saturating minute limit; reaching it sets expired
// PORTS
//  Clk          in   1  system clock
//  Reset_n      in   1  one clock; reset is asynchronous and active-low
//  Start        in   1  1-cycle pulse: begin counting from STOPPED
//  Pause        in   1  level: freeze the count while high (RUNNING<->PAUSED)
//  Clear        in   1  1-cycle pulse: zero all counters, go to STOPPED
//  Step         in   1  1-cycle debug pulse: advance minutes by 1
//  minutes      out  8  game minutes, registered, saturates at MAX_MIN
//  seconds      out  6  game seconds 0..SEC_PER_MIN-1, registered
//  sec_tick     out  1  1-cycle pulse, coincident with each seconds update
//  minute_tick  out  1  1-cycle pulse, coincident with each minutes update
//  running      out  1  1 in RUNNING only
//  expired      out  1  1 in EXPIRED only
// BEHAVIOUR
//  Reset (Reset_n=0, async): state=STOPPED; prescaler, seconds and minutes are 0;
//   all outputs are 0. Reset mid-count discards all progress.
//  Prescaler: width ceil(log2(TICKS_PER_SEC)). Counts only in RUNNING.
//   Terminal value is TICKS_PER_SEC-1. At the terminal value it wraps to 0.
//  Second rollover: on the edge where the prescaler is terminal, seconds+1.
//   If seconds==SEC_PER_MIN-1, seconds wraps to 0 and minutes+1 instead.
//  Tick timing: sec_tick and minute_tick are registered. Each is high for
//   exactly the cycle in which the new seconds/minutes value is visible.
//  minutes never exceeds MAX_MIN. An increment past it clips to MAX_MIN.
//  Step: honoured in RUNNING and PAUSED only. It adds 1 to minutes and pulses
//   minute_tick. seconds and the prescaler are unchanged. If it coincides with a
//   natural rollover, minutes+2 (saturating) and minute_tick is a single pulse.
//  FSM states and transitions (Clear has priority over everything, then Start/Pause):
//   STOPPED: Start -> RUNNING with prescaler=0. Pause is ignored.
//   RUNNING: Pause=1 -> PAUSED. minutes becomes MAX_MIN -> EXPIRED, on the
//            same edge the value is written.
//   PAUSED : prescaler/seconds/minutes are held. Pause=0 -> RUNNING, and
//            counting resumes from the held prescaler value.
//   EXPIRED: all counters frozen. Start, Step and Pause are ignored.
//            Clear -> STOPPED.
//   any    : Clear -> STOPPED, counters 0, ticks 0 on the next cycle.
//  Clear and Start in the same cycle: Clear wins and the block stays STOPPED.
//  Pause and Start in the same cycle from STOPPED: go to RUNNING, then to PAUSED
//   on the next edge if Pause is still high.
//  running/expired are decoded from the registered state (no glitches).
// TESTING  (TICKS_PER_SEC=4, SEC_PER_MIN=3, MAX_MIN=5)
//  1 Start pulse, run 12 cycles -> sec_tick at cycles 4,8,12. At cycle 12:
//    minutes=1, seconds=0, minute_tick=1 for 1 cycle.
//  2 Pause when prescaler=2, hold 10 cycles -> no ticks, counts frozen. Then
//    Pause=0 -> next sec_tick exactly 2 cycles later.
//  3 Run to minutes=5 -> expired=1, running=0. A further 20 cycles and a Start
//    pulse leave minutes=5, seconds=0. Clear -> all 0, STOPPED.
//  4 Step at minutes=3 on the cycle of a natural rollover -> minutes=5,
//    a single minute_tick, expired=1 on the same edge.
//  5 Reset_n low mid-count (minutes=2, seconds=1) -> outputs 0 immediately,
//    without waiting for Clk. Held STOPPED until Start.
//  6 Clear+Start in the same cycle while RUNNING -> STOPPED, counters 0,
//    running=0.

Source files
------------

// File: rtl/lecture_clock.sv
// Game lecture clock: divides Clk into game seconds and minutes with
// run/pause/expire control; minutes saturate at MAX_MIN and then freeze.
module lecture_clock #(
  parameter int unsigned TICKS_PER_SEC = 100_000_000,
  parameter int unsigned SEC_PER_MIN   = 60,
  parameter logic [7:0]  MAX_MIN       = 8'd255
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       Start,
  input  logic       Pause,
  input  logic       Clear,
  input  logic       Step,
  output logic [7:0] minutes,
  output logic [5:0] seconds,
  output logic       sec_tick,
  output logic       minute_tick,
  output logic       running,
  output logic       expired
);

  localparam int unsigned     PRE_W    = $clog2(TICKS_PER_SEC);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICKS_PER_SEC - 1);
  localparam logic [5:0]       SEC_LAST = 6'(SEC_PER_MIN - 1);

  typedef enum logic [1:0] {ST_STOPPED, ST_RUNNING, ST_PAUSED, ST_EXPIRED} state_t;

  state_t           state_q, state_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [5:0]       sec_q, sec_d;
  logic [7:0]       min_q, min_d;
  logic             sec_tick_q, sec_tick_d;
  logic             minute_tick_q, minute_tick_d;
  logic             running_q, running_d;
  logic             expired_q, expired_d;

  logic       active, count_en, wrap_sec, roll_min, step_en;
  logic [1:0] min_inc;

  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [1:0] inc);
    logic [8:0] sum;
    sum = {1'b0, a} + {7'b0, inc};
    if (sum >= {1'b0, MAX_MIN}) return MAX_MIN;
    return sum[7:0];
  endfunction

  // Pause is a level that gates counting even on the edge that enters PAUSED.
  assign active   = (state_q == ST_RUNNING) || (state_q == ST_PAUSED);
  assign count_en = active && !Pause;
  assign wrap_sec = count_en && (pre_q == PRE_LAST);
  assign roll_min = wrap_sec && (sec_q == SEC_LAST);
  assign step_en  = active && Step;
  assign min_inc  = {1'b0, roll_min} + {1'b0, step_en};

  always_comb begin
    state_d       = state_q;
    pre_d         = pre_q;
    sec_d         = sec_q;
    min_d         = min_q;
    sec_tick_d    = 1'b0;
    minute_tick_d = 1'b0;
    if (Clear) begin
      state_d = ST_STOPPED;
      pre_d   = '0;
      sec_d   = '0;
      min_d   = '0;
    end else begin
      case (state_q)
        ST_STOPPED: begin
          if (Start) begin
            state_d = ST_RUNNING;
            pre_d   = '0;
          end
        end
        ST_RUNNING, ST_PAUSED: begin
          if (count_en) pre_d = wrap_sec ? '0 : pre_q + 1'b1;
          if (wrap_sec) begin
            sec_d      = roll_min ? '0 : sec_q + 6'd1;
            sec_tick_d = 1'b1;
          end
          state_d = Pause ? ST_PAUSED : ST_RUNNING;
          // A step coinciding with a rollover merges into one +2 update.
          if (min_inc != 2'd0) begin
            min_d         = sat_add(min_q, min_inc);
            minute_tick_d = 1'b1;
            if (min_d == MAX_MIN) state_d = ST_EXPIRED;
          end
        end
        default: ;
      endcase
    end
    running_d = (state_d == ST_RUNNING);
    expired_d = (state_d == ST_EXPIRED);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q       <= ST_STOPPED;
      pre_q         <= '0;
      sec_q         <= '0;
      min_q         <= '0;
      sec_tick_q    <= 1'b0;
      minute_tick_q <= 1'b0;
      running_q     <= 1'b0;
      expired_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      pre_q         <= pre_d;
      sec_q         <= sec_d;
      min_q         <= min_d;
      sec_tick_q    <= sec_tick_d;
      minute_tick_q <= minute_tick_d;
      running_q     <= running_d;
      expired_q     <= expired_d;
    end
  end

  assign minutes     = min_q;
  assign seconds     = sec_q;
  assign sec_tick    = sec_tick_q;
  assign minute_tick = minute_tick_q;
  assign running     = running_q;
  assign expired     = expired_q;

endmodule

// File: tb/tb_lecture_clock.sv
// Scoreboard bench for lecture_clock: a reference model queues the expected
// outputs for each driven cycle, compared after the edge, plus directed checks.
module tb_lecture_clock;

  localparam int TPS  = 4;
  localparam int SPM  = 3;
  localparam int MAXM = 5;

  logic       Clk, Reset_n, Start, Pause, Clear, Step;
  logic [7:0] minutes;
  logic [5:0] seconds;
  logic       sec_tick, minute_tick, running, expired;
  logic [17:0] out_vec;

  int n_chk = 0;
  int n_err = 0;

  int m_state, m_pre, m_sec, m_min;
  logic [17:0] exp_q[$];

  lecture_clock #(
    .TICKS_PER_SEC(TPS),
    .SEC_PER_MIN(SPM),
    .MAX_MIN(8'd5)
  ) dut (
    .Clk(Clk),
    .Reset_n(Reset_n),
    .Start(Start),
    .Pause(Pause),
    .Clear(Clear),
    .Step(Step),
    .minutes(minutes),
    .seconds(seconds),
    .sec_tick(sec_tick),
    .minute_tick(minute_tick),
    .running(running),
    .expired(expired)
  );

  assign out_vec = {minutes, seconds, sec_tick, minute_tick, running, expired};

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_pre = 0; m_sec = 0; m_min = 0;
    exp_q.delete();
  endtask

  // States: 0 stopped, 1 running, 2 paused, 3 expired.
  task automatic model_edge(input bit st, input bit pa, input bit cl, input bit sp,
                            output logic [17:0] expv);
    int inc;
    bit stk, mtk;
    stk = 0; mtk = 0;
    if (cl) begin
      m_state = 0; m_pre = 0; m_sec = 0; m_min = 0;
    end else if (m_state == 0) begin
      if (st) begin m_state = 1; m_pre = 0; end
    end else if (m_state == 1 || m_state == 2) begin
      inc = 0;
      if (!pa) begin
        if (m_pre == TPS - 1) begin
          m_pre = 0;
          stk = 1;
          if (m_sec == SPM - 1) begin m_sec = 0; inc++; end
          else m_sec++;
        end else m_pre++;
      end
      if (sp) inc++;
      if (inc > 0) begin
        m_min = (m_min + inc >= MAXM) ? MAXM : m_min + inc;
        mtk = 1;
      end
      if (inc > 0 && m_min == MAXM) m_state = 3;
      else m_state = pa ? 2 : 1;
    end
    expv = {8'(m_min), 6'(m_sec), stk, mtk, (m_state == 1), (m_state == 3)};
  endtask

  task automatic cyc(input bit st, input bit pa, input bit cl, input bit sp);
    logic [17:0] e;
    Start = st; Pause = pa; Clear = cl; Step = sp;
    model_edge(st, pa, cl, sp, e);
    exp_q.push_back(e);
    @(posedge Clk);
    @(negedge Clk);
    if (exp_q.size() == 0) chk("sb_empty", 32'd0, 32'd1);
    else chk("sb_cycle", 32'(out_vec), 32'(exp_q.pop_front()));
  endtask

  initial begin
    logic [7:0] hold_min;
    logic [5:0] hold_sec;
    bit pa_lvl;
    int guard;

    Reset_n = 1'b0; Start = 0; Pause = 0; Clear = 0; Step = 0;
    model_reset();
    @(negedge Clk);
    @(negedge Clk);
    chk("reset_outputs", 32'(out_vec), 32'd0);
    Reset_n = 1'b1;

    // Test 1: ticks at 4, 8, 12; minute rollover at 12.
    cyc(1, 0, 0, 0);
    for (int i = 1; i <= 12; i++) begin
      cyc(0, 0, 0, 0);
      chk("t1_sec_tick", 32'(sec_tick), 32'(i == 4 || i == 8 || i == 12));
    end
    chk("t1_minutes", 32'(minutes), 32'd1);
    chk("t1_seconds", 32'(seconds), 32'd0);
    chk("t1_minute_tick", 32'(minute_tick), 32'd1);
    cyc(0, 0, 0, 0);
    chk("t1_minute_tick_off", 32'(minute_tick), 32'd0);

    // Test 2: prescaler is now 1; one more cycle makes it 2, then pause.
    cyc(0, 0, 0, 0);
    hold_min = minutes;
    hold_sec = seconds;
    for (int i = 0; i < 10; i++) begin
      cyc(0, 1, 0, 0);
      chk("t2_no_tick", 32'({sec_tick, minute_tick}), 32'd0);
    end
    chk("t2_paused_running", 32'(running), 32'd0);
    chk("t2_held", 32'({minutes, seconds}), 32'({hold_min, hold_sec}));
    cyc(0, 0, 0, 0);
    chk("t2_resume_1", 32'(sec_tick), 32'd0);
    cyc(0, 0, 0, 0);
    chk("t2_resume_2", 32'(sec_tick), 32'd1);
    chk("t2_seconds", 32'(seconds), 32'd1);

    // Test 5: async reset at minutes=2, seconds=1.
    guard = 0;
    while (!(m_min == 2 && m_sec == 1) && guard < 100) begin
      cyc(0, 0, 0, 0);
      guard++;
    end
    chk("t5_reach", 32'({minutes, seconds}), 32'({8'd2, 6'd1}));
    #1 Reset_n = 1'b0;
    #1 chk("t5_async_zero", 32'(out_vec), 32'd0);
    model_reset();
    @(negedge Clk);
    Reset_n = 1'b1;
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0);
    chk("t5_stays_stopped", 32'(out_vec), 32'd0);

    // Test 6: Clear+Start while running.
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0);
    cyc(1, 0, 1, 0);
    chk("t6_clear_start", 32'(out_vec), 32'd0);
    cyc(0, 0, 0, 0);
    chk("t6_still_stopped", 32'(running), 32'd0);

    // Test 4: step on the rollover edge at minutes=3.
    cyc(1, 0, 0, 0);
    guard = 0;
    while (!(m_min == 3 && m_sec == SPM - 1 && m_pre == TPS - 1) && guard < 200) begin
      cyc(0, 0, 0, 0);
      guard++;
    end
    chk("t4_reach", 32'(minutes), 32'd3);
    cyc(0, 0, 0, 1);
    chk("t4_minutes", 32'(minutes), 32'd5);
    chk("t4_tick", 32'(minute_tick), 32'd1);
    chk("t4_expired", 32'({running, expired}), 32'b01);
    cyc(0, 0, 0, 0);
    chk("t4_single_tick", 32'(minute_tick), 32'd0);
    cyc(0, 0, 1, 0);

    // Test 3: run to expiry, then everything but Clear is ignored.
    cyc(1, 0, 0, 0);
    guard = 0;
    while (!expired && guard < 200) begin
      cyc(0, 0, 0, 0);
      guard++;
    end
    chk("t3_expired", 32'({running, expired}), 32'b01);
    chk("t3_min_sec", 32'({minutes, seconds}), 32'({8'd5, 6'd0}));
    for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 1);
    chk("t3_frozen", 32'({minutes, seconds, expired}), 32'({8'd5, 6'd0, 1'b1}));
    cyc(0, 0, 1, 0);
    chk("t3_clear", 32'(out_vec), 32'd0);

    // Start with Pause held, step while paused, step ignored when stopped.
    cyc(1, 1, 0, 0);
    chk("sp_running", 32'(running), 32'd1);
    cyc(0, 1, 0, 0);
    chk("sp_paused", 32'(running), 32'd0);
    cyc(0, 1, 0, 1);
    chk("sp_step_paused", 32'({minutes, minute_tick, sec_tick}), 32'({8'd1, 1'b1, 1'b0}));
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 1);
    chk("sp_step_stopped", 32'(minutes), 32'd0);

    // Random mix against the model.
    pa_lvl = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) == 0) pa_lvl = ~pa_lvl;
      cyc($urandom_range(0, 7) == 0, pa_lvl, $urandom_range(0, 59) == 0,
          $urandom_range(0, 14) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
